// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: round-robin write-back arbiter onto NUM_PORTS register-file write ports; RISCV_WB_ARB_PERF_EN adds per-producer stall_count.
module riscv_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][4:0]        req_rd,
  input  logic [NUM_REQ-1:0][31:0]       req_data,
  output logic [NUM_PORTS-1:0]           register_write_en,
  output logic [NUM_PORTS-1:0][4:0]      register_write,
  output logic [NUM_PORTS-1:0][31:0]     register_write_data,
  output logic                           busy
`ifdef RISCV_WB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]       stall_count
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_PORTS-1:0] nxt_en;
  logic [NUM_PORTS-1:0][4:0] nxt_addr;
  logic [NUM_PORTS-1:0][31:0] nxt_data;
  logic hit;
  int used, idx;
  // x0 results are acknowledged but never occupy a port or move the pointer
  always_comb begin
    grant = '0;
    nxt_en = '0;
    nxt_addr = '0;
    nxt_data = '0;
    used = 0;
    idx = 0;
    hit = 1'b0;
    rr_nxt = rr_ptr;
    for (int s = 0; s < NUM_REQ; s++) begin
      idx = (int'(rr_ptr) + s) % NUM_REQ;
      hit = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) hit = hit | (nxt_en[p] && nxt_addr[p] == req_rd[idx]);
      if (req_valid[idx] && req_rd[idx] == 5'd0) grant[idx] = 1'b1;
      else if (req_valid[idx] && used < NUM_PORTS && !hit) begin
        grant[idx] = 1'b1;
        nxt_en[used] = 1'b1;
        nxt_addr[used] = req_rd[idx];
        nxt_data[used] = req_data[idx];
        used = used + 1;
        rr_nxt = PW'((idx + 1) % NUM_REQ);
      end
    end
  end
  assign req_ready = reset ? '0 : grant;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      register_write_en <= '0;
      register_write <= '0;
      register_write_data <= '0;
      busy <= 1'b0;
      rr_ptr <= '0;
    end else begin
      register_write_en <= nxt_en;
      register_write <= nxt_addr;
      register_write_data <= nxt_data;
      busy <= |(req_valid & ~grant);
      rr_ptr <= rr_nxt;
    end
  end
`ifdef RISCV_WB_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_count <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && !grant[i] && stall_count[i] != 16'hFFFF) stall_count[i] <= stall_count[i] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed checks of riscv_wb_arbiter with 2-port and 1-port instances.
module tb_riscv_wb_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] ready, ready1;
  logic [3:0][4:0] req_rd = '0;
  logic [3:0][31:0] req_data = '0;
  logic [1:0] en;
  logic [1:0][4:0] wa;
  logic [1:0][31:0] wd;
  logic [0:0] en1;
  logic [0:0][4:0] wa1;
  logic [0:0][31:0] wd1;
  logic busy, busy1;
  logic [4:0] exp_rd;
`ifdef RISCV_WB_ARB_PERF_EN
  logic [3:0][15:0] sc, sc1;
`endif
  int checks = 0;
  int failures = 0;

  riscv_wb_arbiter #(.NUM_REQ(4), .NUM_PORTS(2)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready),
    .req_rd(req_rd), .req_data(req_data), .register_write_en(en),
    .register_write(wa), .register_write_data(wd), .busy(busy)
`ifdef RISCV_WB_ARB_PERF_EN
    , .stall_count(sc)
`endif
  );

  riscv_wb_arbiter #(.NUM_REQ(4), .NUM_PORTS(1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_rd(req_rd), .req_data(req_data), .register_write_en(en1),
    .register_write(wa1), .register_write_data(wd1), .busy(busy1)
`ifdef RISCV_WB_ARB_PERF_EN
    , .stall_count(sc1)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    req_valid = 4'hF;
    req_rd = {5'd4, 5'd3, 5'd2, 5'd1};
    #2;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_en", 32'(en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    do_reset();

    req_valid = 4'b0001; req_rd[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
    #1 check("single_rdy", 32'(ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_en", 32'(en), 32'h1);
    check("single_wa", 32'(wa[0]), 32'd5);
    check("single_wd", wd[0], 32'hDEADBEEF);
    check("single_busy", 32'(busy), 32'h0);
    do_reset();

    req_valid = 4'hF;
    req_rd = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data = {32'h103, 32'h102, 32'h101, 32'h100};
    #1 check("over_rdy0", 32'(ready), 32'h3);
    tick();
    req_valid = 4'b1100;
    check("over_en1", 32'(en), 32'h3);
    check("over_wa1", {22'd0, wa[1], wa[0]}, {22'd0, 5'd2, 5'd1});
    check("over_busy1", 32'(busy), 32'h1);
    #1 check("over_rdy1", 32'(ready), 32'hC);
    tick();
    req_valid = '0;
    check("over_en2", 32'(en), 32'h3);
    check("over_wa2", {22'd0, wa[1], wa[0]}, {22'd0, 5'd4, 5'd3});
    check("over_wd2", wd[0], 32'h102);
    check("over_busy2", 32'(busy), 32'h0);
    do_reset();

    req_valid = 4'b0110;
    req_rd[1] = 5'd7; req_rd[2] = 5'd7;
    req_data[1] = 32'h11; req_data[2] = 32'h22;
    #1 check("conf_rdy0", 32'(ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    check("conf_en1", 32'(en), 32'h1);
    check("conf_wa1", 32'(wa[0]), 32'd7);
    check("conf_wd1", wd[0], 32'h11);
    #1 check("conf_rdy1", 32'(ready), 32'h4);
    tick();
    req_valid = '0;
    check("conf_en2", 32'(en), 32'h1);
    check("conf_wd2", wd[0], 32'h22);
    do_reset();

    req_valid = 4'b0111;
    req_rd[0] = 5'd0; req_rd[1] = 5'd9; req_rd[2] = 5'd10;
    req_data[0] = 32'hBAD; req_data[1] = 32'h9; req_data[2] = 32'hA;
    #1 check("x0_rdy", 32'(ready), 32'h7);
    tick();
    req_valid = '0;
    check("x0_en", 32'(en), 32'h3);
    check("x0_wa", {22'd0, wa[1], wa[0]}, {22'd0, 5'd10, 5'd9});
    check("x0_wd", wd[0], 32'h9);
    do_reset();

    req_valid = 4'hF;
    req_rd = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 8; c++) begin
      #1 check("fair_rdy", 32'(ready1), 32'(1 << (c % 4)));
      exp_rd = req_rd[c % 4];
      tick();
      check("fair_en", 32'(en1), 32'h1);
      check("fair_wa", 32'(wa1[0]), 32'(exp_rd));
      req_rd[c % 4] = req_rd[c % 4] + 5'd4;
    end
    do_reset();

    req_valid = 4'b0111;
    req_rd = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data = {32'h0, 32'hC3, 32'hC2, 32'hC1};
    tick();
    check("ar_en_pre", 32'(en), 32'h3);
    check("ar_busy_pre", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("ar_en", 32'(en), 32'h0);
    check("ar_wa", {22'd0, wa[1], wa[0]}, 32'h0);
    check("ar_wd", wd[0] | wd[1], 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_rdy", 32'(ready), 32'h0);
`ifdef RISCV_WB_ARB_PERF_EN
    check("ar_stall", 32'(|sc), 32'h0);
`endif
    #1 reset = 1'b0;
    req_valid = 4'hF;
    #1 check("ar_scan0", 32'(ready), 32'h3);
    tick();
    check("ar_wa_post", {22'd0, wa[1], wa[0]}, {22'd0, 5'd2, 5'd1});
    req_valid = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
